// File: rtl/rs_sym_packer_if.sv
// Handshake bundle between the block source, the symbol packer and the RS encoder.
// The packer connects through the slave view; the surrounding logic drives the master view.
interface rs_sym_packer_if #(
   parameter int BLK_W = 257,
   parameter int SYM_W = 10
) ();
   logic             in_valid;
   logic             in_ready;
   logic [BLK_W-1:0] in_data;
   logic             enc_ready;
   logic             enc_sop;
   logic             enc_valid;
   logic [SYM_W-1:0] enc_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      output enc_ready,
      input  enc_sop,
      input  enc_valid,
      input  enc_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      input  enc_ready,
      output enc_sop,
      output enc_valid,
      output enc_data
   );
endinterface

// File: rtl/rs_sym_packer.sv
// Repacks 257-bit transcoded blocks LSB-first into 10-bit RS symbols and frames
// every K symbols as one codeword for the downstream rs_encoder.
module rs_sym_packer #(
   parameter int BLK_W = 257,
   parameter int SYM_W = 10,
   parameter int K     = 514
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   rs_sym_packer_if.slave  bus,
   output logic            underrun
);

   localparam int BUF_W   = BLK_W + 2*SYM_W - 1;
   localparam int FILL_W  = $clog2(BUF_W + 1);
   localparam int CNT_W   = $clog2(K);
   localparam int RDY_MAX = BUF_W - BLK_W;

   logic [BUF_W-1:0]  bits_q, bits_d, bits_sh;
   logic [FILL_W-1:0] fill_q, fill_d, fill_sh;
   logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic              sop_q, sop_d;
   logic              valid_q, valid_d;
   logic [SYM_W-1:0]  data_q, data_d;
   logic              underrun_q, underrun_d;
   logic              at_start, accept, emit;

   // Ready depends only on the fill register so upstream never sees a comb path from in_valid.
   assign bus.in_ready  = (fill_q <= FILL_W'(RDY_MAX));
   assign bus.enc_sop   = sop_q;
   assign bus.enc_valid = valid_q;
   assign bus.enc_data  = data_q;
   assign underrun      = underrun_q;

   always_comb begin
      at_start = (sym_cnt_q == '0);
      accept   = bus.in_valid && bus.in_ready;
      emit     = (fill_q >= FILL_W'(SYM_W)) && (!at_start || bus.enc_ready);

      bits_sh  = emit ? (bits_q >> SYM_W) : bits_q;
      fill_sh  = emit ? (fill_q - FILL_W'(SYM_W)) : fill_q;

      // Bits at and above fill are always zero, so a new block can be OR-ed in place.
      bits_d   = bits_sh;
      fill_d   = fill_sh;
      if (accept) begin
         bits_d = bits_sh | (BUF_W'(bus.in_data) << fill_sh);
         fill_d = fill_sh + FILL_W'(BLK_W);
      end

      sym_cnt_d = sym_cnt_q;
      if (emit) begin
         sym_cnt_d = (sym_cnt_q == CNT_W'(K - 1)) ? '0 : sym_cnt_q + 1'b1;
      end

      valid_d    = emit;
      sop_d      = emit && at_start;
      data_d     = emit ? bits_q[SYM_W-1:0] : '0;
      underrun_d = underrun_q || (!at_start && (fill_q < FILL_W'(SYM_W)));

      if (clr) begin
         bits_d     = '0;
         fill_d     = '0;
         sym_cnt_d  = '0;
         valid_d    = 1'b0;
         sop_d      = 1'b0;
         data_d     = '0;
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q     <= '0;
         fill_q     <= '0;
         sym_cnt_q  <= '0;
         sop_q      <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         bits_q     <= bits_d;
         fill_q     <= fill_d;
         sym_cnt_q  <= sym_cnt_d;
         sop_q      <= sop_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

endmodule

// File: tb/tb_rs_sym_packer.sv
// Self-checking bench for rs_sym_packer: a bit-queue reference model supplies the expected
// symbol stream, framing and the handshake rules each cycle.
module tb_rs_sym_packer;
   localparam int BLK_W = 257;
   localparam int SYM_W = 10;
   localparam int K     = 514;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic clr   = 1'b0;
   logic underrun;

   rs_sym_packer_if #(.BLK_W(BLK_W), .SYM_W(SYM_W)) bus ();

   rs_sym_packer #(.BLK_W(BLK_W), .SYM_W(SYM_W), .K(K)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .bus      (bus),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   bit               ref_bits[$];
   logic [BLK_W-1:0] blk_q[$];
   logic [SYM_W-1:0] obs_data[$];
   bit               obs_sop[$];
   int               obs_cyc[$];
   bit               und_m;
   int               blk_acc, cyc_n;
   int               rdy_bad, tim_bad, idle_bad;
   int               n_cmp, n_err;
   logic [BLK_W-1:0] ones  = '1;
   logic [BLK_W-1:0] zeros = '0;

   function automatic logic [BLK_W-1:0] rand_blk();
      logic [BLK_W-1:0] r = '0;
      for (int w = 0; w < 9; w++) r = (r << 32) | BLK_W'($urandom);
      return r;
   endfunction

   // Expected symbol idx: the idx-th group of 10 bits of everything accepted, earliest bit first.
   function automatic logic [SYM_W-1:0] ref_sym(int idx);
      logic [SYM_W-1:0] s = '0;
      for (int b = 0; b < SYM_W; b++) s[b] = ref_bits[idx*SYM_W + b];
      return s;
   endfunction

   task automatic clear_model();
      ref_bits.delete(); blk_q.delete();
      obs_data.delete(); obs_sop.delete(); obs_cyc.delete();
      und_m = 1'b0; blk_acc = 0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.enc_ready = 1'b0; clr = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      clear_model();
      rdy_bad = 0; tim_bad = 0; idle_bad = 0;
      @(posedge clk); #1;
   endtask

   // One clock: drive inputs, apply the handshake rules to predict ready/valid/underrun,
   // then record what the packer emitted.
   task automatic cycle(input logic v, input logic [BLK_W-1:0] d, input logic er, input logic c);
      int   fill_m, n_sym;
      logic acc, exp_v, exp_u;
      bus.in_valid = v; bus.in_data = d; bus.enc_ready = er; clr = c;
      @(negedge clk);
      n_sym  = obs_data.size();
      fill_m = ref_bits.size() - SYM_W*n_sym;
      if (bus.in_ready !== (fill_m <= 19)) rdy_bad++;
      acc   = v && bus.in_ready;
      exp_v = !c && (fill_m >= SYM_W) && (((n_sym % K) != 0) || er);
      exp_u = !c && (und_m || (((n_sym % K) != 0) && (fill_m < SYM_W)));
      @(posedge clk); #1;
      cyc_n++;
      clr = 1'b0;
      if (c) clear_model();
      else begin
         if (acc) begin
            for (int b = 0; b < BLK_W; b++) ref_bits.push_back(d[b]);
            blk_q.push_back(d);
            blk_acc++;
         end
         und_m = exp_u;
      end
      if (bus.enc_valid !== exp_v || underrun !== exp_u) tim_bad++;
      if (bus.enc_valid === 1'b1) begin
         obs_data.push_back(bus.enc_data);
         obs_sop.push_back(bus.enc_sop);
         obs_cyc.push_back(cyc_n);
      end else if (bus.enc_sop !== 1'b0 || bus.enc_data !== '0) idle_bad++;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.enc_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.enc_sop !== 1'b0) begin n_err++; $display("FAIL reset_sop: got %b want 0", bus.enc_sop); end
      n_cmp++; if (bus.enc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.enc_valid); end
      n_cmp++; if (bus.enc_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 000", bus.enc_data); end
      n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      do_reset();
   endtask

   task automatic test_all_ones();
      int shown = 0, nsop = 0;
      do_reset();
      for (int t = 0; t < 1500 && obs_data.size() < K; t++) cycle(blk_acc < 20, ones, 1'b1, 1'b0);
      repeat (20) cycle(1'b0, zeros, 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != K) begin n_err++; $display("FAIL ones_count: got %0d want %0d", obs_data.size(), K); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== 10'h3FF) begin n_err++; if (shown++ < 4) $display("FAIL ones_sym[%0d]: got %h want 3ff", i, obs_data[i]); end
         if (obs_sop[i]) nsop++;
      end
      n_cmp++; if (nsop != 1 || obs_sop.size() == 0 || !obs_sop[0]) begin n_err++; $display("FAIL ones_sop: got %0d sops want 1 on symbol 0", nsop); end
      n_cmp++; if (obs_cyc.size() < K || obs_cyc[K-1] - obs_cyc[0] != K-1) begin n_err++; $display("FAIL ones_gapfree: got span mismatch want %0d cycles", K); end
      n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ones_underrun: got %b want 0", underrun); end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL ones_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   task automatic test_alternating();
      int shown = 0;
      do_reset();
      for (int t = 0; t < 1500 && obs_data.size() < K; t++)
         cycle(blk_acc < 20, (blk_acc % 2 == 0) ? ones : zeros, 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != K) begin n_err++; $display("FAIL alt_count: got %0d want %0d", obs_data.size(), K); end
      n_cmp++; if (obs_data.size() > 26 && (obs_data[24] !== 10'h3FF || obs_data[25] !== 10'h07F || obs_data[26] !== 10'h000)) begin
         n_err++; $display("FAIL alt_boundary: got %h %h %h want 3ff 07f 000", obs_data[24], obs_data[25], obs_data[26]); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== ref_sym(i) || obs_sop[i] !== (i % K == 0)) begin
            n_err++; if (shown++ < 4) $display("FAIL alt_sym[%0d]: got %h/%b want %h/%b", i, obs_data[i], obs_sop[i], ref_sym(i), i % K == 0); end
      end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL alt_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   task automatic test_ready_hold();
      logic [BLK_W-1:0] d0;
      do_reset();
      d0 = rand_blk();
      repeat (12) cycle(1'b1, d0, 1'b0, 1'b0);
      n_cmp++; if (obs_data.size() != 0) begin n_err++; $display("FAIL hold_no_valid: got %0d symbols want 0", obs_data.size()); end
      n_cmp++; if (blk_acc != 1) begin n_err++; $display("FAIL hold_accepts: got %0d want 1", blk_acc); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); end
      cycle(1'b0, zeros, 1'b1, 1'b0);
      n_cmp++; if (bus.enc_sop !== 1'b1 || bus.enc_valid !== 1'b1) begin n_err++; $display("FAIL hold_start: got sop=%b valid=%b want 1 1", bus.enc_sop, bus.enc_valid); end
      n_cmp++; if (bus.enc_data !== d0[9:0]) begin n_err++; $display("FAIL hold_sym0: got %h want %h", bus.enc_data, d0[9:0]); end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL hold_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   task automatic test_underrun();
      int shown = 0;
      do_reset();
      cycle(1'b1, rand_blk(), 1'b1, 1'b0);
      repeat (40) cycle(1'b0, zeros, 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != 25) begin n_err++; $display("FAIL urun_prefix: got %0d symbols want 25", obs_data.size()); end
      n_cmp++; if (underrun !== 1'b1 || bus.enc_valid !== 1'b0) begin n_err++; $display("FAIL urun_flag: got underrun=%b valid=%b want 1 0", underrun, bus.enc_valid); end
      for (int t = 0; t < 1500 && obs_data.size() < K; t++) cycle(blk_acc < 20, rand_blk(), 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != K) begin n_err++; $display("FAIL urun_count: got %0d want %0d", obs_data.size(), K); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== ref_sym(i) || obs_sop[i] !== (i % K == 0)) begin
            n_err++; if (shown++ < 4) $display("FAIL urun_sym[%0d]: got %h/%b want %h/%b", i, obs_data[i], obs_sop[i], ref_sym(i), i % K == 0); end
      end
      n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL urun_sticky: got %b want 1", underrun); end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL urun_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   task automatic test_two_codewords();
      int shown = 0, hold = 0, nb, nsop = 0;
      do_reset();
      for (int t = 0; t < 3000 && obs_data.size() < 2*K; t++) begin
         nb = obs_data.size();
         cycle(blk_acc < 40, rand_blk(), hold == 0, 1'b0);
         if (hold > 0) hold--;
         if (obs_data.size() != nb && obs_data.size() % K == 0) hold = 30;
      end
      n_cmp++; if (obs_data.size() != 2*K) begin n_err++; $display("FAIL two_count: got %0d want %0d", obs_data.size(), 2*K); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== ref_sym(i)) begin n_err++; if (shown++ < 4) $display("FAIL two_sym[%0d]: got %h want %h", i, obs_data[i], ref_sym(i)); end
         if (obs_sop[i]) nsop++;
      end
      n_cmp++; if (nsop != 2 || obs_sop.size() < 2*K || !obs_sop[0] || !obs_sop[K]) begin n_err++; $display("FAIL two_sop: got %0d sops want 2 at 0 and %0d", nsop, K); end
      n_cmp++; if (obs_data.size() < 2*K || blk_q.size() < 21 || obs_data[K] !== blk_q[20][9:0]) begin n_err++; $display("FAIL two_cw2_sym0: second codeword symbol 0 not block 20 bits [9:0]"); end
      n_cmp++; if (obs_cyc.size() < 2*K || obs_cyc[K] - obs_cyc[K-1] != 31) begin n_err++; $display("FAIL two_sop_wait: got gap mismatch want 31 cycles"); end
      n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL two_underrun: got %b want 0", underrun); end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL two_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   task automatic test_random();
      int shown = 0;
      do_reset();
      for (int t = 0; t < 6000 && obs_data.size() < 2*K; t++)
         cycle((blk_acc < 40) && ($urandom_range(3) != 0), rand_blk(), 1'($urandom_range(1)), 1'b0);
      n_cmp++; if (obs_data.size() != 2*K) begin n_err++; $display("FAIL rand_count: got %0d want %0d", obs_data.size(), 2*K); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== ref_sym(i) || obs_sop[i] !== (i % K == 0)) begin
            n_err++; if (shown++ < 4) $display("FAIL rand_sym[%0d]: got %h/%b want %h/%b", i, obs_data[i], obs_sop[i], ref_sym(i), i % K == 0); end
      end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL rand_rules: got rdy=%0d tim=%0d idle=%0d want 0", rdy_bad, tim_bad, idle_bad); end
   endtask

   // Abandon a codeword at symbol 300 with either the async reset or the sync clear.
   task automatic test_abort(input bit use_clr);
      int shown = 0;
      do_reset();
      cycle(1'b1, rand_blk(), 1'b1, 1'b0);
      repeat (30) cycle(1'b0, zeros, 1'b1, 1'b0);
      for (int t = 0; t < 1000 && obs_data.size() < 300; t++) cycle(1'b1, rand_blk(), 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != 300 || underrun !== 1'b1) begin n_err++; $display("FAIL abort_pre[%0d]: got %0d symbols underrun=%b want 300 1", use_clr, obs_data.size(), underrun); end
      if (use_clr) cycle(1'b0, zeros, 1'b1, 1'b1);
      else begin
         #1 rst_n = 1'b0;
         #1;
      end
      n_cmp++; if (bus.enc_valid !== 1'b0 || bus.enc_sop !== 1'b0 || bus.enc_data !== '0) begin
         n_err++; $display("FAIL abort_outputs[%0d]: got valid=%b sop=%b data=%h want 0 0 000", use_clr, bus.enc_valid, bus.enc_sop, bus.enc_data); end
      n_cmp++; if (underrun !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL abort_flags[%0d]: got underrun=%b in_ready=%b want 0 1", use_clr, underrun, bus.in_ready); end
      if (!use_clr) do_reset();
      for (int t = 0; t < 1500 && obs_data.size() < K; t++) cycle(blk_acc < 20, rand_blk(), 1'b1, 1'b0);
      n_cmp++; if (obs_data.size() != K || !obs_sop[0]) begin n_err++; $display("FAIL abort_fresh[%0d]: got %0d symbols want %0d starting with sop", use_clr, obs_data.size(), K); end
      foreach (obs_data[i]) begin
         n_cmp++;
         if (obs_data[i] !== ref_sym(i) || obs_sop[i] !== (i % K == 0)) begin
            n_err++; if (shown++ < 4) $display("FAIL abort_sym[%0d][%0d]: got %h/%b want %h/%b", use_clr, i, obs_data[i], obs_sop[i], ref_sym(i), i % K == 0); end
      end
      n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL abort_underrun[%0d]: got %b want 0", use_clr, underrun); end
      n_cmp++; if (rdy_bad + tim_bad + idle_bad != 0) begin n_err++; $display("FAIL abort_rules[%0d]: got rdy=%0d tim=%0d idle=%0d want 0", use_clr, rdy_bad, tim_bad, idle_bad); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc_n = 0;
      test_reset();
      test_all_ones();
      test_alternating();
      test_ready_hold();
      test_underrun();
      test_two_codewords();
      test_random();
      test_abort(1'b0);
      test_abort(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
